mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, parametrised in operand width. Sits beside the EX-stage ALU: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX, runs multi-cycle arithmetic, and drives a stall request toward the hazard logic while busy. MFHI/MFLO read `hi`/`lo` combinationally.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 4, even)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  issue request for `op`, qualified by EX-stage valid
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-ops
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTxx data)
- `b`  in  WIDTH  rt operand (divisor / multiplier)
- `mf_req`  in  1  an instruction in EX reads HI or LO
- `flush`  in  1  squash the in-flight operation (branch/jump redirect)
- `busy`  out  1  operation in progress
- `stall`  out  1  combinational: `busy & (start | mf_req)`
- `done`  out  1  one-cycle pulse on the edge that writes HI/LO
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start` & op ∈ {MULT..DIVU}: latch |a|, |b| (magnitudes for signed ops, raw values for unsigned), result-sign and remainder-sign flags, clear partial product/remainder, counter ← WIDTH-1, go to CALC.
- IDLE, `start` & MTHI/MTLO: write `a` into `hi`/`lo` on that edge. Stay in IDLE; `busy` stays 0.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC, counter = 0: go to FIX.
- FIX: apply sign fix-ups and write HI/LO.
  - Multiply: {hi,lo} ← product, negated if the operand signs differ.
  - Divide: lo ← quotient, hi ← remainder. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Pulse `done`, return to IDLE.
- Divide by zero: lo ← all ones, hi ← a (unmodified dividend). Same latency as a normal divide.
- Signed overflow (a = −2^(WIDTH−1), b = −1): lo ← −2^(WIDTH−1), hi ← 0.
- `start` while `busy`: ignored. The pipeline holds the instruction via `stall` and re-presents it.
- `flush` in CALC or FIX: go to IDLE on the next edge. HI/LO are not written and `done` is not pulsed.
- `flush` and `start` in the same cycle in IDLE: flush wins and the start is dropped. This also applies to MTHI/MTLO.
- `op` codes 110/111 with `start`: no effect.

## Timing
- Reset: `hi` = `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0.
- Reset deassertion mid-operation: the unit restarts in IDLE and the aborted result is lost.
- Start accepted at edge E0. `busy` is 1 from after E0 through edge E0+WIDTH+1.
  - CALC occupies edges E0+1 … E0+WIDTH.
  - FIX writes HI/LO at edge E0+WIDTH+1; `done` is high in the cycle ending at that edge.
  - A new start is accepted at E0+WIDTH+2 at the earliest.
- Latency for WIDTH = 32: 33 cycles from acceptance to the HI/LO write.
- MTHI/MTLO latency: 1 edge. `hi`/`lo` hold the new value in the following cycle.
- `stall` is purely combinational from `busy`, `start`, `mf_req`. There is no registered path.

## Structure
- Shared package `mips_pkg`:
  - `muldiv_op_t` enum for the op codes.
  - `muldiv_state_t` enum (IDLE/CALC/FIX).
  - Localparam `MD_CNT_W = $clog2(WIDTH)`.
- One sub-module, `md_negate`: parametrised two's-complement conditional negate (`y = s ? -x : x`). It is instantiated for operand magnitudes and for the result fix-ups.
- Datapath registers: `acc_hi`, `acc_lo` (WIDTH each), `divisor_r`, counter, sign flags, `is_div`. The accumulator pair is shared between multiply and divide.

## Test plan
- MULT a = 7, b = −3 (WIDTH = 32) → after 33 cycles, hi = FFFFFFFF, lo = FFFFFFEB. `done` pulses once; `busy` is high for exactly 33 cycles.
- DIVU a = 100, b = 7 → lo = 0000000E, hi = 00000002. DIV a = −7, b = 2 → lo = FFFFFFFD, hi = FFFFFFFF.
- DIV b = 0, a = 5 → lo = FFFFFFFF, hi = 00000005. DIV a = 80000000, b = FFFFFFFF → lo = 80000000, hi = 0.
- MTHI 1234, then MULTU started; `mf_req` asserted 5 cycles later → `stall` = 1 until `done`. A back-to-back start during `busy` is ignored until re-presented.
- MULTU a = FFFFFFFF, b = FFFFFFFF with `flush` at cycle 10 → `busy` drops next edge, hi/lo keep their prior values (1234/0), no `done`. `reset` low mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states,
// and the per-operation control flags latched when an op is accepted.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // Sign handling decided at issue time and applied in FIX.
  typedef struct packed {
    logic is_div;
    logic res_neg;
    logic rem_neg;
  } md_ctl_t;

  function automatic int md_cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

endpackage

// File: rtl/mips_muldiv_if.sv
// Issue/result bundle between the EX stage (master) and the mul/div unit (slave).
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mf_req;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mf_req, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mf_req, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_negate.sv
// Conditional two's-complement negate: y = s ? -x : x.
module md_negate #(parameter int W = 32) (
  input  logic         s,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = s ? (~x + W'(1)) : x;
endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO. One result bit per cycle:
// shift-add multiply, restoring divide, sign fix-up in a final FIX cycle.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mips_muldiv_if.slave md
);

  localparam int               CNT_W    = md_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       S_IDLE   = ST_IDLE;
  localparam logic [1:0]       S_CALC   = ST_CALC;
  localparam logic [1:0]       S_FIX    = ST_FIX;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, divisor_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  md_ctl_t          ctl;

  // Issue-side decode and operand magnitudes
  logic             is_signed, a_s, b_s, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~md.op[0];
  assign a_s       = is_signed & md.a[WIDTH-1];
  assign b_s       = is_signed & md.b[WIDTH-1];
  assign b_zero    = (md.b == '0);

  md_negate #(.W(WIDTH)) u_abs_a (.s(a_s), .x(md.a), .y(a_mag));
  md_negate #(.W(WIDTH)) u_abs_b (.s(b_s), .x(md.b), .y(b_mag));

  // One iteration of each algorithm
  logic [WIDTH:0] mul_sum, rem_sh, rem_diff;
  logic           rem_ge;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor_r} : '0);
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, divisor_r});
  assign rem_diff = rem_sh - {1'b0, divisor_r};

  // Result fix-ups
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  md_negate #(.W(2*WIDTH)) u_fix_p (.s(ctl.res_neg), .x({acc_hi, acc_lo}), .y(prod_fix));
  md_negate #(.W(WIDTH))   u_fix_q (.s(ctl.res_neg), .x(acc_lo), .y(quo_fix));
  md_negate #(.W(WIDTH))   u_fix_r (.s(ctl.rem_neg), .x(acc_hi), .y(rem_fix));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      divisor_r <= '0;
      ctl       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md.start && !md.flush) begin
            if (!md.op[2]) begin
              state  <= S_CALC;
              cnt    <= CNT_LAST;
              acc_hi <= '0;
              // A zero divisor keeps the all-ones quotient un-negated.
              ctl    <= '{is_div:  md.op[1],
                          res_neg: (a_s ^ b_s) & ~(md.op[1] & b_zero),
                          rem_neg: a_s};
              if (md.op[1]) begin
                acc_lo    <= a_mag;
                divisor_r <= b_mag;
              end else begin
                acc_lo    <= b_mag;
                divisor_r <= a_mag;
              end
            end else if (md.op == OP_MTHI) begin
              hi_r <= md.a;
            end else if (md.op == OP_MTLO) begin
              lo_r <= md.a;
            end
          end
        end
        S_CALC: begin
          if (md.flush) begin
            state <= S_IDLE;
          end else begin
            if (ctl.is_div) begin
              acc_hi <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!md.flush) begin
            if (ctl.is_div) begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end else begin
              {hi_r, lo_r} <= prod_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md.hi    = hi_r;
  assign md.lo    = lo_r;
  assign md.busy  = (state != S_IDLE);
  assign md.stall = md.busy & (md.start | md.mf_req);
  assign md.done  = (state == S_FIX) & ~md.flush;

endmodule

// File: tb/tb_mips_muldiv.sv
// Randomised check of mips_muldiv against a plain-arithmetic HI/LO model,
// plus directed timing, stall, flush and reset scenarios.
module tb_mips_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(W)) md_bus();

  mips_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always @(posedge clk) if (md_bus.done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction on HI/LO.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sq, sr;
    longint unsigned up;
    case (op)
      3'b000: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        {exp_hi, exp_lo} = sq;
      end
      3'b001: begin
        up = 64'(a) * 64'(b);
        {exp_hi, exp_lo} = up;
      end
      3'b010: begin
        if (b == '0) begin
          exp_lo = '1; exp_hi = a;
        end else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          exp_lo = sq[W-1:0]; exp_hi = sr[W-1:0];
        end
      end
      3'b011: begin
        if (b == '0) begin
          exp_lo = '1; exp_hi = a;
        end else begin
          exp_lo = a / b; exp_hi = a % b;
        end
      end
      3'b100: exp_hi = a;
      3'b101: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    md_bus.start = 1'b1; md_bus.op = op; md_bus.a = a; md_bus.b = b;
    @(posedge clk);
    #1 md_bus.start = 1'b0;
  endtask

  task automatic run_arith(input string tag, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    int nb, nd;
    logic fin;
    issue(op, a, b);
    model(op, a, b);
    nb = 0; nd = 0; fin = 1'b0;
    for (int j = 0; j < 100 && !fin; j++) begin
      @(negedge clk);
      if (md_bus.done) nd++;
      if (!md_bus.busy) fin = 1'b1;
      else nb++;
    end
    chk({tag, " finished"}, fin, 1'b1);
    chk({tag, " busy cycles"}, nb, W + 1);
    chk({tag, " done pulses"}, nd, 1);
    chk({tag, " hi"}, md_bus.hi, exp_hi);
    chk({tag, " lo"}, md_bus.lo, exp_lo);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic fl);
    @(negedge clk);
    md_bus.start = 1'b1; md_bus.op = op; md_bus.a = a; md_bus.flush = fl;
    @(posedge clk);
    #1 md_bus.start = 1'b0; md_bus.flush = 1'b0;
    if (!fl) model(op, a, '0);
    @(negedge clk);
    chk({tag, " hi"}, md_bus.hi, exp_hi);
    chk({tag, " lo"}, md_bus.lo, exp_lo);
    chk({tag, " busy"}, md_bus.busy, 1'b0);
  endtask

  initial begin
    int d0, r;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;

    md_bus.start = 1'b0; md_bus.op = '0; md_bus.a = '0; md_bus.b = '0;
    md_bus.mf_req = 1'b0; md_bus.flush = 1'b0;
    #2;
    chk("reset hi", md_bus.hi, '0);
    chk("reset lo", md_bus.lo, '0);
    chk("reset busy", md_bus.busy, 1'b0);
    chk("reset done", md_bus.done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed arithmetic, including the divide corner cases
    run_arith("mult 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD);
    chk("mult 7*-3 const hi", md_bus.hi, 32'hFFFF_FFFF);
    chk("mult 7*-3 const lo", md_bus.lo, 32'hFFFF_FFEB);
    run_arith("divu 100/7", 3'b011, 32'd100, 32'd7);
    chk("divu const", {md_bus.hi, md_bus.lo}, {32'h2, 32'hE});
    run_arith("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2);
    chk("div -7/2 const", {md_bus.hi, md_bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_arith("div 5/0", 3'b010, 32'd5, 32'd0);
    chk("div0 const", {md_bus.hi, md_bus.lo}, {32'h5, 32'hFFFF_FFFF});
    run_arith("div -5/0", 3'b010, 32'hFFFF_FFFB, 32'd0);
    run_arith("div ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div ovf const", {md_bus.hi, md_bus.lo}, {32'h0, 32'h8000_0000});

    // MTHI/MTLO, flush-dropped MTHI, reserved op
    run_mt("mthi", 3'b100, 32'h1234, 1'b0);
    run_mt("mtlo", 3'b101, 32'h0, 1'b0);
    run_mt("mthi flushed", 3'b100, 32'hBEEF, 1'b1);
    run_mt("op 110", 3'b110, 32'h5555, 1'b0);

    // Flush mid-CALC: no write, no done
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    d0 = done_cnt;
    repeat (9) @(posedge clk);
    #1 chk("flush pre busy", md_bus.busy, 1'b1);
    md_bus.flush = 1'b1;
    @(posedge clk);
    #1 md_bus.flush = 1'b0;
    @(negedge clk);
    chk("flush busy", md_bus.busy, 1'b0);
    chk("flush hi", md_bus.hi, 32'h1234);
    chk("flush lo", md_bus.lo, 32'h0);
    chk("flush no done", done_cnt, d0);

    // Flush landing on the FIX cycle
    issue(3'b001, 32'd3, 32'd4);
    repeat (W + 1) @(negedge clk);
    md_bus.flush = 1'b1;
    #1 chk("fix flush done", md_bus.done, 1'b0);
    @(posedge clk);
    #1 md_bus.flush = 1'b0;
    @(negedge clk);
    chk("fix flush busy", md_bus.busy, 1'b0);
    chk("fix flush hi/lo", {md_bus.hi, md_bus.lo}, {exp_hi, exp_lo});

    // Stall while busy; a start presented during busy only lands once re-presented
    issue(3'b001, 32'h0001_2345, 32'h0000_0100);
    model(3'b001, 32'h0001_2345, 32'h0000_0100);
    repeat (4) @(posedge clk);
    #1 md_bus.mf_req = 1'b1;
    md_bus.start = 1'b1; md_bus.op = 3'b101; md_bus.a = 32'hDEAD_0000;
    for (int j = 5; j <= 34; j++) begin
      @(negedge clk);
      chk($sformatf("stall c%0d", j), md_bus.stall, (j <= 33));
      chk($sformatf("done c%0d", j), md_bus.done, (j == 33));
    end
    chk("stall result", {md_bus.hi, md_bus.lo}, {exp_hi, exp_lo});
    @(posedge clk);
    #1 md_bus.start = 1'b0; md_bus.mf_req = 1'b0;
    model(3'b101, 32'hDEAD_0000, '0);
    @(negedge clk);
    chk("represented mtlo", {md_bus.hi, md_bus.lo}, {exp_hi, exp_lo});

    // Asynchronous reset in the middle of CALC
    issue(3'b000, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    md_bus.mf_req = 1'b1;
    #1;
    chk("midreset hi/lo", {md_bus.hi, md_bus.lo}, 64'h0);
    chk("midreset busy", md_bus.busy, 1'b0);
    chk("midreset done", md_bus.done, 1'b0);
    chk("midreset stall", md_bus.stall, 1'b0);
    exp_hi = '0; exp_lo = '0;
    md_bus.mf_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Randomised mix
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 11);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = '1; end
        default: ;
      endcase
      if (r < 8) begin
        rop = 3'(r % 4);
        run_arith($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
      end else begin
        rop = (r == 11) ? 3'b111 : 3'(r - 4);
        run_mt($sformatf("rnd%0d op%0d", i, rop), rop, ra, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
